// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
//   Shared definitions for the two-requester RAM arbiter.
//   - state_t : controller state (zero-fill sweep, then normal arbitration)
//   - id_t    : requester identity, used for the round-robin `last` pointer
//               and for steering read responses back to their owner
// ---------------------------------------------------------------------------
package ram_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef logic id_t;

   localparam id_t ID_A = 1'b0;
   localparam id_t ID_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Pure combinational two-way grant logic. At most one grant is ever high.
//   Ports:
//     req_a, req_b   in   requests from A and B (already qualified by caller)
//     last           in   identity of the most recent winner
//     fixed_prio     in   1 = A always wins a tie, 0 = alternate on ties
//     gnt_a, gnt_b   out  one-hot-or-zero grants
// ---------------------------------------------------------------------------
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  id_t  last,
   input  logic fixed_prio,
   output logic gnt_a,
   output logic gnt_b
);

   logic a_wins_tie;

   always_comb begin
      // On a tie A wins if priority is fixed, or if B had the previous turn.
      a_wins_tie = fixed_prio || (last == ID_B);
      gnt_a      = req_a && (!req_b || a_wins_tie);
      gnt_b      = req_b && !gnt_a;
   end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port synchronous RAM (registered read, 1-cycle latency,
//   read-before-write) between requester A (CPU data) and requester B
//   (loader/display). After reset the RAM is zero-filled by a sweep over all
//   addresses; afterwards one access per cycle is granted and read data is
//   returned one cycle after the grant.
//
//   Handshake: a requester raises x_req with x_we/x_addr/x_wdata and holds
//   them stable until it sees x_gnt. The access is transferred in the cycle
//   where x_req && x_gnt. x_gnt is combinational and may be low for any
//   number of cycles. Read data comes back as x_rvalid/x_rdata exactly one
//   cycle after a read transfer; there is no response backpressure.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     a_req/a_we/a_addr/a_wdata   requester A command
//     a_gnt                 A transfer accepted this cycle (combinational)
//     a_rvalid/a_rdata      A read response (rdata is 0 when rvalid is 0)
//     b_*                   same set for requester B
//     mem_address/mem_load/mem_in  RAM command
//     mem_out               RAM read data (registered inside the RAM)
//     init_done             1 once the zero-fill sweep has completed
//     debug_state           current controller state
// ---------------------------------------------------------------------------
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,

   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,

   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_load,
   output logic [DATA_WIDTH-1:0] mem_in,
   input  logic [DATA_WIDTH-1:0] mem_out,

   output logic                  init_done,
   output state_t                debug_state
);

   localparam logic                  FIXED   = (FIXED_PRIO != 0);
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] CNT_MAX = {ADDR_WIDTH{1'b1}};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                  state;
   logic [ADDR_WIDTH-1:0]   cnt;        // zero-fill sweep address
   id_t                     last;       // most recent winner
   logic [ADDR_WIDTH-1:0]   addr_q;     // address driven last cycle
   logic                    rsp_valid;  // a read was transferred last cycle
   id_t                     rsp_id;     // ... and this requester owns it

   // ------------------------------------------------------------------
   // Grant logic. Requests are masked outside RUN so that nothing is
   // granted during the sweep, and masked by reset so grants drop
   // immediately when reset is asserted.
   // ------------------------------------------------------------------
   logic run_en;
   logic req_a_q;
   logic req_b_q;

   assign run_en  = (state == ST_RUN) && !reset;
   assign req_a_q = a_req && run_en;
   assign req_b_q = b_req && run_en;

   rr_arbiter2 u_arb (
      .req_a      (req_a_q),
      .req_b      (req_b_q),
      .last       (last),
      .fixed_prio (FIXED),
      .gnt_a      (a_gnt),
      .gnt_b      (b_gnt)
   );

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
   logic                  xfer;
   id_t                   win_id;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   always_comb begin
      xfer      = a_gnt || b_gnt;
      win_id    = b_gnt ? ID_B : ID_A;
      win_we    = b_gnt ? b_we    : a_we;
      win_addr  = b_gnt ? b_addr  : a_addr;
      win_wdata = b_gnt ? b_wdata : a_wdata;
   end

   // ------------------------------------------------------------------
   // RAM command mux. With no winner the address is parked on its last
   // value and load stays low, so an idle cycle can never write.
   // ------------------------------------------------------------------
   always_comb begin
      mem_address = addr_q;
      mem_load    = 1'b0;
      mem_in      = '0;
      if (reset) begin
         mem_load = 1'b0;
      end else if (state == ST_INIT) begin
         mem_address = cnt;
         mem_load    = 1'b1;
         mem_in      = '0;
      end else if (xfer) begin
         mem_address = win_addr;
         mem_load    = win_we;
         mem_in      = win_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Controller: sweep counter, state, round-robin pointer and the
   // one-deep read response pipeline. Reset drops any pending response.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_INIT;
         cnt       <= '0;
         last      <= ID_B;
         addr_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= ID_A;
         init_done <= 1'b0;
      end else begin
         addr_q    <= mem_address;
         rsp_valid <= xfer && !win_we;
         rsp_id    <= win_id;
         case (state)
            ST_INIT: begin
               cnt <= cnt + CNT_ONE;
               // The cycle that writes the top address is the last sweep cycle.
               if (cnt == CNT_MAX) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  last <= win_id;
               end
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Response steering: decoded from flops only, so rvalid is glitch-free.
   // ------------------------------------------------------------------
   always_comb begin
      a_rvalid = rsp_valid && (rsp_id == ID_A);
      b_rvalid = rsp_valid && (rsp_id == ID_B);
      a_rdata  = a_rvalid ? mem_out : '0;
      b_rdata  = b_rvalid ? mem_out : '0;
   end

   assign debug_state = state;

endmodule
